// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: frame constants, baud derivation and the
// receiver state type.
package uart_rx_pkg;

  // 8N1 frame: 8 data bits, no parity, stop bit(s) high.
  localparam int DATA_BITS = 8;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  // Clocks per bit for a given system clock and line rate.
  function automatic int baud_count(input int clk_speed, input int baud_rate);
    return clk_speed / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous input pin. The reset value is a
// parameter so idle-high and idle-low pins can both come out of reset quietly.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver. Recovers LSB-first frames from the rx pin and delivers
// each byte with a one-cycle rx_valid strobe; a low stop bit gives a one-cycle
// rx_error strobe and the receiver then waits for the line to go high again.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_SPEED = 12000000,
  parameter int BAUD_RATE = 19200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_error,
  output logic       rx_busy
);

  localparam int BAUD_COUNT = baud_count(CLK_SPEED, BAUD_RATE);
  localparam int HALF_COUNT = BAUD_COUNT / 2;
  localparam int CNT_W      = $clog2(BAUD_COUNT);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_COUNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_COUNT - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 sync_live;

  rx_state_t            state_reg,    state_next;
  logic [CNT_W-1:0]     baud_cnt_reg, baud_cnt_next;
  logic [2:0]           bit_idx_reg,  bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg,    shift_next;
  logic [7:0]           rx_byte_reg,  rx_byte_next;
  logic                 rx_valid_reg, rx_valid_next;
  logic                 rx_error_reg, rx_error_next;
  logic                 armed_reg,    armed_next;
  logic                 sample_en;

  uart_sync #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Goes high exactly when the rx synchronizer holds real pin samples rather
  // than its reset fill, so a line held low through reset cannot arm us.
  uart_sync #(.RESET_VAL(1'b0)) u_fill (
    .clk (clk),
    .rst (rst),
    .d   (1'b1),
    .q   (sync_live)
  );

  // Each shift bit loads rx_s only at its own data-bit sample point.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_BITS; gi++) begin : g_shift
      assign shift_next[gi] = (sample_en && (bit_idx_reg == 3'(gi))) ? rx_s : shift_reg[gi];
    end
  endgenerate

  // Next-state logic for the frame FSM, bit timing and output strobes.
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    rx_byte_next  = rx_byte_reg;
    rx_valid_next = 1'b0;
    rx_error_next = 1'b0;
    sample_en     = 1'b0;
    armed_next    = armed_reg | (sync_live & rx_s);

    case (state_reg)
      IDLE: begin
        if (armed_reg && !rx_s) begin
          state_next    = START;
          baud_cnt_next = '0;
        end
      end
      START: begin
        if (baud_cnt_reg == HALF_LAST) begin
          baud_cnt_next = '0;
          if (!rx_s) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end else begin
            state_next = IDLE;  // too short to be a start bit
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_cnt_reg == BAUD_LAST) begin
          baud_cnt_next = '0;
          sample_en     = 1'b1;
          if (bit_idx_reg == BIT_LAST) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_cnt_reg == BAUD_LAST) begin
          baud_cnt_next = '0;
          if (rx_s) begin
            rx_byte_next  = shift_reg;
            rx_valid_next = 1'b1;
            state_next    = IDLE;  // back in IDLE mid stop bit: no gap needed
          end else begin
            rx_error_next = 1'b1;
            state_next    = BREAK;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + CNT_W'(1);
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      rx_byte_reg  <= '0;
      rx_valid_reg <= 1'b0;
      rx_error_reg <= 1'b0;
      armed_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      rx_byte_reg  <= rx_byte_next;
      rx_valid_reg <= rx_valid_next;
      rx_error_reg <= rx_error_next;
      armed_reg    <= armed_next;
    end
  end

  assign rx_byte  = rx_byte_reg;
  assign rx_valid = rx_valid_reg;
  assign rx_error = rx_error_reg;
  assign rx_busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_error;
  logic       rx_busy;

  int checks      = 0;
  int failures    = 0;
  int cyc         = 0;
  int valid_cnt   = 0;
  int err_cnt     = 0;
  int overlap_cnt = 0;
  int last_valid_cyc = 0;
  int start_cyc   = 0;
  logic [7:0] byte_q[$];

  uart_rx #(.CLK_SPEED(1600), .BAUD_RATE(100)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_error (rx_error),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      byte_q.push_back(rx_byte);
      last_valid_cyc = cyc;
    end
    if (rx_error) err_cnt++;
    if (rx_valid && rx_error) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) tick();
  endtask

  // One frame: start, 8 data bits LSB first, stop. With alt set the data
  // bits alternate between t+1 and t clocks to model a skewed sender.
  task automatic send_frame(input logic [7:0] b, input int t, input bit alt,
                            input int stop_len, input logic stop_v);
    int len;
    start_cyc = cyc;
    drive(1'b0, t);
    for (int k = 0; k < 8; k++) begin
      len = (alt && (k % 2 == 0)) ? t + 1 : t;
      drive(b[k], len);
    end
    drive(stop_v, stop_len);
  endtask

  initial begin
    int v0, e0, qb, lat;

    // Reset state
    rx  = 1'b1;
    rst = 1'b1;
    repeat (5) tick();
    check("reset_busy",  {31'd0, rx_busy},  32'd0);
    check("reset_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_error", {31'd0, rx_error}, 32'd0);
    check("reset_byte",  {24'd0, rx_byte},  32'd0);
    rst = 1'b0;
    drive(1'b1, 10);

    // 1: single 0xA5 frame, strobe latency
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'hA5, 16, 1'b0, 16, 1'b1);
    drive(1'b1, 20);
    lat = last_valid_cyc - start_cyc;
    check("t1_valid_count", valid_cnt - v0, 1);
    check("t1_byte", {24'd0, rx_byte}, 32'hA5);
    check("t1_no_error", err_cnt - e0, 0);
    check("t1_latency_155pm1", {31'd0, (lat >= 154 && lat <= 156)}, 32'd1);
    $display("t1 byte=%02h latency=%0d", rx_byte, lat);

    // 2: back-to-back frames with two stop bits
    v0 = valid_cnt; qb = byte_q.size();
    send_frame(8'h00, 16, 1'b0, 32, 1'b1);
    send_frame(8'hFF, 16, 1'b0, 32, 1'b1);
    send_frame(8'h55, 16, 1'b0, 32, 1'b1);
    drive(1'b1, 10);
    check("t2_valid_count", valid_cnt - v0, 3);
    check("t2_byte0", (byte_q.size() > qb)     ? {24'd0, byte_q[qb]}     : 32'hFFFF_FFFF, 32'h00);
    check("t2_byte1", (byte_q.size() > qb + 1) ? {24'd0, byte_q[qb + 1]} : 32'hFFFF_FFFF, 32'hFF);
    check("t2_byte2", (byte_q.size() > qb + 2) ? {24'd0, byte_q[qb + 2]} : 32'hFFFF_FFFF, 32'h55);
    $display("t2 received %0d bytes", valid_cnt - v0);

    // 3: short low glitch
    v0 = valid_cnt;
    drive(1'b0, 4);
    drive(1'b1, 2);
    check("t3_busy_during", {31'd0, rx_busy}, 32'd1);
    drive(1'b1, 20);
    check("t3_busy_after", {31'd0, rx_busy}, 32'd0);
    check("t3_no_valid", valid_cnt - v0, 0);
    $display("t3 glitch rejected busy=%0b", rx_busy);

    // 4: framing error, held-low line, then recovery
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h3C, 16, 1'b0, 56, 1'b0);
    drive(1'b1, 20);
    check("t4_error_count", err_cnt - e0, 1);
    check("t4_no_valid", valid_cnt - v0, 0);
    check("t4_byte_kept", {24'd0, rx_byte}, 32'h55);
    send_frame(8'h3C, 16, 1'b0, 16, 1'b1);
    drive(1'b1, 20);
    check("t4_recover_count", valid_cnt - v0, 1);
    check("t4_recover_byte", {24'd0, rx_byte}, 32'h3C);
    $display("t4 errors=%0d byte=%02h", err_cnt - e0, rx_byte);

    // 5: reset during bit 4 of 0xE7 (bit 4 is 0, so the line stays low)
    v0 = valid_cnt; e0 = err_cnt;
    drive(1'b0, 16);
    drive(1'b1, 16);
    drive(1'b1, 16);
    drive(1'b1, 16);
    drive(1'b0, 16);
    drive(1'b0, 8);
    rst = 1'b1;
    tick();
    check("t5_busy", {31'd0, rx_busy}, 32'd0);
    check("t5_valid", {31'd0, rx_valid}, 32'd0);
    check("t5_error", {31'd0, rx_error}, 32'd0);
    check("t5_byte", {24'd0, rx_byte}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 12);
    check("t5_low_ignored", {31'd0, rx_busy}, 32'd0);
    drive(1'b1, 20);
    send_frame(8'h42, 16, 1'b0, 16, 1'b1);
    drive(1'b1, 20);
    check("t5_valid_count", valid_cnt - v0, 1);
    check("t5_recover_byte", {24'd0, rx_byte}, 32'h42);
    check("t5_no_error", err_cnt - e0, 0);
    $display("t5 after reset byte=%02h", rx_byte);

    // 6: slow sender (17 clk/bit) and fast sender (15/16 clk/bit alternating)
    v0 = valid_cnt;
    send_frame(8'h96, 17, 1'b0, 17, 1'b1);
    drive(1'b1, 20);
    check("t6_slow_count", valid_cnt - v0, 1);
    check("t6_slow_byte", {24'd0, rx_byte}, 32'h96);
    $display("t6 slow byte=%02h", rx_byte);
    drive(1'b1, 10);
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h69, 15, 1'b1, 16, 1'b1);
    drive(1'b1, 20);
    check("t6_fast_count", valid_cnt - v0, 1);
    check("t6_fast_byte", {24'd0, rx_byte}, 32'h69);
    check("t6_no_error", err_cnt - e0, 0);
    $display("t6 fast byte=%02h", rx_byte);

    check("strobe_overlap", overlap_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
